// File: rtl/scmp_mem_arb.sv
// rtl/scmp_mem_arb.sv - SC/MP program RAM arbiter: CPU/debug round-robin, 3-cycle access sequencer
module scmp_mem_arb #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [11:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_hold,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    input  logic              dbg_halt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              grant_dbg
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t state;
    logic   cpu_armed;
    logic   dbg_armed;
    logic   last_dbg;
    logic   cur_we;
    logic   cpu_elig;
    logic   dbg_elig;
    logic   pick_dbg;
    logic   addr_unused;

    // CPU addresses above the RAM window simply mirror.
    assign addr_unused = ^cpu_addr[11:ADDR_W];

    assign cpu_elig = cpu_req & cpu_armed & ~dbg_halt;
    assign dbg_elig = dbg_req & dbg_armed;
    assign pick_dbg = dbg_elig & (~cpu_elig | ~last_dbg);
    assign cpu_hold = (cpu_req & cpu_armed & ~cpu_ack) | dbg_halt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_ack   <= 1'b0;
            dbg_ack   <= 1'b0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
            cpu_armed <= 1'b1;
            dbg_armed <= 1'b1;
            last_dbg  <= 1'b1;
            grant_dbg <= 1'b0;
            cur_we    <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            dbg_ack <= 1'b0;
            case (state)
                IDLE: begin
                    // A requester must show req=0 before it can be granted again.
                    if (!cpu_req) cpu_armed <= 1'b1;
                    if (!dbg_req) dbg_armed <= 1'b1;
                    if (cpu_elig || dbg_elig) begin
                        state     <= ACCESS;
                        mem_en    <= 1'b1;
                        grant_dbg <= pick_dbg;
                        last_dbg  <= pick_dbg;
                        if (pick_dbg) begin
                            mem_we    <= dbg_we;
                            cur_we    <= dbg_we;
                            mem_addr  <= dbg_addr;
                            mem_wdata <= dbg_wdata;
                        end else begin
                            mem_we    <= cpu_we;
                            cur_we    <= cpu_we;
                            mem_addr  <= cpu_addr[ADDR_W-1:0];
                            mem_wdata <= cpu_wdata;
                        end
                    end
                end
                ACCESS: begin
                    state  <= DONE;
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                end
                DONE: begin
                    state <= IDLE;
                    if (grant_dbg) begin
                        dbg_ack   <= 1'b1;
                        dbg_armed <= 1'b0;
                        if (!cur_we) dbg_rdata <= mem_rdata;
                    end else begin
                        cpu_ack   <= 1'b1;
                        cpu_armed <= 1'b0;
                        if (!cur_we) cpu_rdata <= mem_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scmp_mem_arb.sv
// tb/tb_scmp_mem_arb.sv - self-checking bench for scmp_mem_arb with RAM model and shadow-memory reference
module tb_scmp_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        cpu_ack, cpu_hold;
    logic        dbg_req, dbg_we;
    logic [4:0]  dbg_addr;
    logic [7:0]  dbg_wdata, dbg_rdata;
    logic        dbg_ack, dbg_halt;
    logic        mem_en, mem_we;
    logic [4:0]  mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        grant_dbg;

    logic [7:0]  ram [32];
    logic [7:0]  sh  [32];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    scmp_mem_arb #(.ADDR_W(5), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_hold(cpu_hold),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack), .dbg_halt(dbg_halt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .grant_dbg(grant_dbg)
    );

    // One complete single-port transaction; req is released as soon as the ack is seen.
    task automatic do_xfer(input bit dbg, input bit we, input logic [11:0] addr, input logic [7:0] wd,
                           output logic [7:0] rd, output int lat, output int acks, output int we_cyc);
        @(negedge clk);
        if (dbg) begin
            dbg_req = 1; dbg_we = we; dbg_addr = addr[4:0]; dbg_wdata = wd;
        end else begin
            cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        end
        lat = -1; acks = 0; we_cyc = 0; rd = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_we) we_cyc++;
            if (dbg ? dbg_ack : cpu_ack) begin
                acks++;
                if (lat < 0) begin
                    lat = k;
                    rd = dbg ? dbg_rdata : cpu_rdata;
                    if (dbg) dbg_req = 0; else cpu_req = 0;
                end
            end
        end
        cpu_req = 0; dbg_req = 0;
    endtask

    task automatic contend(output int ca, output int da, output logic g1, output logic g4,
                           output logic [7:0] cr, output logic [7:0] dr);
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h025;
        dbg_req = 1; dbg_we = 0; dbg_addr = 5'd31;
        ca = -1; da = -1; g1 = 0; g4 = 0; cr = 0; dr = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) g1 = grant_dbg;
            if (k == 4) g4 = grant_dbg;
            if (cpu_ack && ca < 0) begin ca = k; cr = cpu_rdata; cpu_req = 0; end
            if (dbg_ack && da < 0) begin da = k; dr = dbg_rdata; dbg_req = 0; end
        end
        cpu_req = 0; dbg_req = 0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        int acks;
        logic [7:0] rd;
        int lat, a2, wc;
        rst = 1;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, cpu_ack, dbg_ack, cpu_rdata, dbg_rdata, grant_dbg, cpu_hold} !== '0) begin
            errors++; $display("FAIL reset_values: got %h required 0",
                {mem_en, mem_we, mem_addr, mem_wdata, cpu_ack, dbg_ack, cpu_rdata, dbg_rdata, grant_dbg, cpu_hold});
        end
        rst = 0;
        @(negedge clk);
        cpu_req = 1; cpu_we = 1; cpu_addr = 12'h003; cpu_wdata = 8'h11;
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b1) begin errors++; $display("FAIL reset_pre_access: mem_en %b required 1", mem_en); end
        rst = 1; cpu_req = 0;
        acks = 0;
        repeat (2) begin @(negedge clk); acks += int'(cpu_ack) + int'(dbg_ack); end
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, cpu_ack, dbg_ack, cpu_rdata, dbg_rdata, grant_dbg, cpu_hold} !== '0) begin
            errors++; $display("FAIL reset_mid_access: got %h required 0",
                {mem_en, mem_we, mem_addr, mem_wdata, cpu_ack, dbg_ack, cpu_rdata, dbg_rdata, grant_dbg, cpu_hold});
        end
        rst = 0;
        repeat (4) begin @(negedge clk); acks += int'(cpu_ack) + int'(dbg_ack); end
        checks++;
        if (acks !== 0) begin errors++; $display("FAIL reset_no_ack: acks %0d required 0", acks); end
        checks++;
        if (ram[3] !== 8'h11) begin errors++; $display("FAIL reset_strobed_write: ram[3] %h required 11", ram[3]); end
        do_xfer(1, 0, 12'd3, 8'h00, rd, lat, a2, wc);
        checks++;
        if (lat !== 3 || rd !== 8'h11) begin
            errors++; $display("FAIL reset_idle_after: latency %0d data %h required 3 / 11", lat, rd);
        end
    endtask

    task automatic test_cpu_read();
        logic [7:0] rd, crd;
        int lat, acks, wc, first;
        do_xfer(1, 1, 12'd5, 8'hA7, rd, lat, acks, wc);
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h025;
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 5'd5}) begin
            errors++; $display("FAIL cpu_read_strobe: en/we/addr %b/%b/%0d required 1/0/5", mem_en, mem_we, mem_addr);
        end
        first = -1; acks = 0; crd = 8'h00;
        for (int k = 2; k <= 12; k++) begin
            @(negedge clk);
            if (cpu_ack) begin
                acks++;
                if (first < 0) begin first = k; crd = cpu_rdata; end
            end
        end
        cpu_req = 0;
        checks++;
        if (first !== 3) begin errors++; $display("FAIL cpu_read_latency: %0d required 3", first); end
        checks++;
        if (crd !== 8'hA7) begin errors++; $display("FAIL cpu_read_data: %h required a7", crd); end
        checks++;
        if (acks !== 1) begin errors++; $display("FAIL cpu_read_held_req: acks %0d required 1", acks); end
        @(negedge clk);
    endtask

    task automatic test_dbg_write_cpu_read();
        logic [7:0] rd;
        int lat, acks, wc;
        do_xfer(1, 1, 12'd31, 8'h3C, rd, lat, acks, wc);
        checks++;
        if (lat !== 3 || acks !== 1 || wc !== 1) begin
            errors++; $display("FAIL dbg_write: latency %0d acks %0d we_cycles %0d required 3/1/1", lat, acks, wc);
        end
        do_xfer(0, 0, 12'hFFF, 8'h00, rd, lat, acks, wc);
        checks++;
        if (lat !== 3 || rd !== 8'h3C) begin
            errors++; $display("FAIL cpu_read_mirror: latency %0d data %h required 3 / 3c", lat, rd);
        end
    endtask

    task automatic test_contention();
        int ca, da, lat, acks, wc;
        logic g1, g4;
        logic [7:0] cr, dr, rd;
        pulse_reset();
        contend(ca, da, g1, g4, cr, dr);
        checks++;
        if ({ca, da} !== {32'sd3, 32'sd6} || g1 !== 1'b0 || g4 !== 1'b1) begin
            errors++; $display("FAIL contention_cpu_first: cpu_ack@%0d dbg_ack@%0d grant_dbg %b->%b required 3/6 0->1", ca, da, g1, g4);
        end
        checks++;
        if (cr !== 8'hA7 || dr !== 8'h3C) begin
            errors++; $display("FAIL contention_data: cpu %h dbg %h required a7/3c", cr, dr);
        end
        do_xfer(0, 0, 12'h005, 8'h00, rd, lat, acks, wc);
        contend(ca, da, g1, g4, cr, dr);
        checks++;
        if ({ca, da} !== {32'sd6, 32'sd3} || g1 !== 1'b1 || g4 !== 1'b0) begin
            errors++; $display("FAIL contention_round_robin: cpu_ack@%0d dbg_ack@%0d grant_dbg %b->%b required 6/3 1->0", ca, da, g1, g4);
        end
    endtask

    task automatic test_halt();
        int ca, da, cacks;
        logic h1, h3, hold_ok;
        logic [7:0] crd;
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h005;
        @(negedge clk);
        dbg_halt = 1;
        ca = -1;
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            if (cpu_ack && ca < 0) begin ca = k; cpu_req = 0; end
        end
        checks++;
        if (ca !== 3) begin errors++; $display("FAIL halt_inflight_ack: ack@%0d required 3", ca); end
        cpu_req = 1; cpu_addr = 12'h009;
        dbg_req = 1; dbg_we = 1; dbg_addr = 5'd9; dbg_wdata = 8'h66;
        da = -1; cacks = 0; hold_ok = 1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (cpu_ack) cacks++;
            if (cpu_hold !== 1'b1) hold_ok = 0;
            if (dbg_ack && da < 0) begin da = k; dbg_req = 0; end
        end
        dbg_req = 0;
        checks++;
        if (da !== 3 || cacks !== 0 || hold_ok !== 1'b1) begin
            errors++; $display("FAIL halt_blocks_cpu: dbg_ack@%0d cpu_acks %0d hold_ok %b required 3/0/1", da, cacks, hold_ok);
        end
        dbg_halt = 0;
        ca = -1; h1 = 0; h3 = 1; crd = 8'h00;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) h1 = cpu_hold;
            if (cpu_ack && ca < 0) begin ca = k; h3 = cpu_hold; crd = cpu_rdata; cpu_req = 0; end
        end
        cpu_req = 0;
        checks++;
        if (ca !== 3 || h1 !== 1'b1 || h3 !== 1'b0 || crd !== 8'h66) begin
            errors++; $display("FAIL halt_release: ack@%0d hold %b->%b data %h required 3 1->0 66", ca, h1, h3, crd);
        end
        @(negedge clk);
    endtask

    task automatic test_write_integrity();
        logic [7:0] r0;
        int ca;
        @(negedge clk);
        r0 = cpu_rdata;
        cpu_req = 1; cpu_we = 1; cpu_addr = 12'h007; cpu_wdata = 8'h5A;
        @(negedge clk);
        cpu_wdata = 8'hFF;
        ca = -1;
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            if (cpu_ack && ca < 0) begin ca = k; cpu_req = 0; end
        end
        cpu_req = 0;
        checks++;
        if (ca !== 3 || ram[7] !== 8'h5A) begin
            errors++; $display("FAIL write_integrity: ack@%0d ram[7] %h required 3 / 5a", ca, ram[7]);
        end
        checks++;
        if (cpu_rdata !== r0) begin errors++; $display("FAIL write_rdata_hold: %h required %h", cpu_rdata, r0); end
    endtask

    task automatic test_random();
        logic [7:0] rd, cwd, dwd, exp_c, exp_d, got_c, got_d;
        logic [11:0] caddr;
        logic [4:0]  daddr;
        bit last_dbg, cw, dw, cpu_win, we;
        int lat, acks, wc, mode, ca, da, exp_ca, exp_da;
        pulse_reset();
        last_dbg = 1;
        for (int a = 0; a < 32; a++) begin
            sh[a] = 8'($urandom);
            do_xfer(1, 1, 12'(a), sh[a], rd, lat, acks, wc);
            last_dbg = 1;
        end
        for (int it = 0; it < 40; it++) begin
            mode = $urandom_range(0, 2);
            if (mode < 2) begin
                we = 1'($urandom);
                caddr = 12'($urandom);
                cwd = 8'($urandom);
                exp_c = sh[caddr[4:0]];
                do_xfer(mode == 1, we, caddr, cwd, rd, lat, acks, wc);
                if (we) sh[caddr[4:0]] = cwd;
                last_dbg = (mode == 1);
                checks++;
                if (lat !== 3 || acks !== 1 || (!we && rd !== exp_c)) begin
                    errors++; $display("FAIL random_single[%0d]: port %0d we %b addr %h latency %0d acks %0d data %h required 3/1/%h",
                        it, mode, we, caddr, lat, acks, rd, exp_c);
                end
            end else begin
                cw = 1'($urandom); dw = 1'($urandom);
                caddr = 12'($urandom); daddr = 5'($urandom);
                cwd = 8'($urandom); dwd = 8'($urandom);
                cpu_win = last_dbg;
                exp_c = 8'h00; exp_d = 8'h00;
                if (cpu_win) begin
                    if (cw) sh[caddr[4:0]] = cwd; else exp_c = sh[caddr[4:0]];
                    if (dw) sh[daddr] = dwd; else exp_d = sh[daddr];
                end else begin
                    if (dw) sh[daddr] = dwd; else exp_d = sh[daddr];
                    if (cw) sh[caddr[4:0]] = cwd; else exp_c = sh[caddr[4:0]];
                end
                exp_ca = cpu_win ? 3 : 6;
                exp_da = cpu_win ? 6 : 3;
                @(negedge clk);
                cpu_req = 1; cpu_we = cw; cpu_addr = caddr; cpu_wdata = cwd;
                dbg_req = 1; dbg_we = dw; dbg_addr = daddr; dbg_wdata = dwd;
                ca = -1; da = -1; got_c = 8'h00; got_d = 8'h00;
                for (int k = 1; k <= 10; k++) begin
                    @(negedge clk);
                    if (cpu_ack && ca < 0) begin ca = k; got_c = cpu_rdata; cpu_req = 0; end
                    if (dbg_ack && da < 0) begin da = k; got_d = dbg_rdata; dbg_req = 0; end
                end
                cpu_req = 0; dbg_req = 0;
                last_dbg = cpu_win;
                checks++;
                if (ca !== exp_ca || da !== exp_da || (!cw && got_c !== exp_c) || (!dw && got_d !== exp_d)) begin
                    errors++; $display("FAIL random_contend[%0d]: acks %0d/%0d data %h/%h required %0d/%0d %h/%h",
                        it, ca, da, got_c, got_d, exp_ca, exp_da, exp_c, exp_d);
                end
            end
        end
    endtask

    initial begin
        rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_halt = 0;
        test_reset();
        test_cpu_read();
        test_dbg_write_cpu_read();
        test_contention();
        test_halt();
        test_write_integrity();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
